// File: rtl/vga_box_plotter_if.sv
// rtl/vga_box_plotter_if.sv - command and pixel-stream bundle for the box plotter
interface vga_box_plotter_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int DIM_W    = 4
);
    logic                start;
    logic                clear;
    logic                outline;
    logic [X_W-1:0]      x_in;
    logic [Y_W-1:0]      y_in;
    logic [DIM_W-1:0]    w_in;
    logic [DIM_W-1:0]    h_in;
    logic [COLOUR_W-1:0] colour_in;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output start, clear, outline, x_in, y_in, w_in, h_in, colour_in,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, clear, outline, x_in, y_in, w_in, h_in, colour_in,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/vga_box_plotter.sv
// rtl/vga_box_plotter.sv - filled/outline box and screen-clear pixel generator
// Optional PLOTTER_CLIP_EN: suppress plot for pixels beyond the visible screen.
module vga_box_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int DIM_W    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input logic              CLOCK_50,
    input logic              resetn,
    vga_box_plotter_if.slave bus
);
    // Offset counters must also span the full screen for the clear path.
    localparam int XC_W = ($clog2(SCREEN_W + 1) > DIM_W) ? $clog2(SCREEN_W + 1) : DIM_W;
    localparam int YC_W = ($clog2(SCREEN_H + 1) > DIM_W) ? $clog2(SCREEN_H + 1) : DIM_W;

    typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2} state_t;

    state_t              state_q;
    logic [X_W-1:0]      x0_q, x_q, x0_d, x_d;
    logic [Y_W-1:0]      y0_q, y_q, y0_d, y_d;
    logic [XC_W-1:0]     w_q, xo_q, w_d, xo_d;
    logic [YC_W-1:0]     h_q, yo_q, h_d, yo_d;
    logic [COLOUR_W-1:0] col_q, colour_q, col_d;
    logic                outl_q, outl_d, plot_q, plot_d, busy_q, done_q;
    logic                last_col, last_pix, border, zero_go, box_go;
`ifdef PLOTTER_CLIP_EN
    logic [X_W:0]        x_full;
    logic [Y_W:0]        y_full;
`endif

    // The next pixel is derived either from the live inputs (launch) or the latched box.
    always_comb begin
        last_col = (xo_q == w_q - XC_W'(1));
        last_pix = last_col && (yo_q == h_q - YC_W'(1));
        zero_go  = bus.start && !bus.clear && ((bus.w_in == '0) || (bus.h_in == '0));
        box_go   = bus.clear || (bus.start && !zero_go);
        if (state_q == IDLE) begin
            xo_d = '0;
            yo_d = '0;
            if (bus.clear) begin
                x0_d   = '0;
                y0_d   = '0;
                w_d    = XC_W'(SCREEN_W);
                h_d    = YC_W'(SCREEN_H);
                col_d  = '0;
                outl_d = 1'b0;
            end else begin
                x0_d   = bus.x_in;
                y0_d   = bus.y_in;
                w_d    = XC_W'(bus.w_in);
                h_d    = YC_W'(bus.h_in);
                col_d  = bus.colour_in;
                outl_d = bus.outline;
            end
        end else begin
            x0_d   = x0_q;
            y0_d   = y0_q;
            w_d    = w_q;
            h_d    = h_q;
            col_d  = col_q;
            outl_d = outl_q;
            xo_d   = last_col ? '0 : xo_q + XC_W'(1);
            yo_d   = last_col ? yo_q + YC_W'(1) : yo_q;
        end
        border = (xo_d == '0) || (xo_d == w_d - XC_W'(1)) ||
                 (yo_d == '0) || (yo_d == h_d - YC_W'(1));
`ifdef PLOTTER_CLIP_EN
        x_full = (X_W+1)'(x0_d) + (X_W+1)'(xo_d);
        y_full = (Y_W+1)'(y0_d) + (Y_W+1)'(yo_d);
        x_d    = x_full[X_W-1:0];
        y_d    = y_full[Y_W-1:0];
        plot_d = (!outl_d || border) &&
                 (x_full < (X_W+1)'(SCREEN_W)) && (y_full < (Y_W+1)'(SCREEN_H));
`else
        x_d    = x0_d + X_W'(xo_d);
        y_d    = y0_d + Y_W'(yo_d);
        plot_d = !outl_d || border;
`endif
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            xo_q     <= '0;
            yo_q     <= '0;
            col_q    <= '0;
            outl_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (box_go) begin
                        state_q  <= DRAW;
                        x0_q     <= x0_d;
                        y0_q     <= y0_d;
                        w_q      <= w_d;
                        h_q      <= h_d;
                        col_q    <= col_d;
                        outl_q   <= outl_d;
                        xo_q     <= '0;
                        yo_q     <= '0;
                        x_q      <= x_d;
                        y_q      <= y_d;
                        colour_q <= col_d;
                        plot_q   <= plot_d;
                        busy_q   <= 1'b1;
                    end else if (zero_go) begin
                        state_q <= DONE;
                    end
                end
                DRAW: begin
                    if (last_pix) begin
                        state_q <= DONE;
                        plot_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        xo_q   <= xo_d;
                        yo_q   <= yo_d;
                        x_q    <= x_d;
                        y_q    <= y_d;
                        plot_q <= plot_d;
                    end
                end
                DONE: begin
                    // A zero-size box arrives here with done low and pulses it one cycle later.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_vga_box_plotter.sv
// tb/tb_vga_box_plotter.sv - randomized self-checking bench for vga_box_plotter
module tb_vga_box_plotter;
    localparam int X_W = 8, Y_W = 7, COLOUR_W = 3, DIM_W = 4, SW = 160, SH = 120;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    vga_box_plotter_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .DIM_W(DIM_W)) bus ();

    vga_box_plotter #(
        .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .DIM_W(DIM_W),
        .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .CLOCK_50(clk),
        .resetn  (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] c;
        logic                p;
    } pix_t;

    pix_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Raster-order list of every pixel cycle the box should produce.
    task automatic build(input int xin, yin, w, h, c, outl);
        pix_t e;
        exp_q.delete();
        for (int yo = 0; yo < h; yo++) begin
            for (int xo = 0; xo < w; xo++) begin
                int ux = xin + xo;
                int uy = yin + yo;
                e.x = X_W'(ux % 256);
                e.y = Y_W'(uy % 128);
                e.c = COLOUR_W'(c);
                e.p = (outl == 0) || xo == 0 || xo == w - 1 || yo == 0 || yo == h - 1;
`ifdef PLOTTER_CLIP_EN
                if (ux >= SW || uy >= SH) e.p = 1'b0;
`endif
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_box(input int xin, yin, w, h, c, outl,
                           input bit do_start, do_clr, noisy, output int plots);
        int bad = 0;
        logic [20:0] act_t, exp_t, f_act, f_exp;
        int f_i = -1;
        plots = 0;
        bus.x_in = X_W'(xin); bus.y_in = Y_W'(yin);
        bus.w_in = DIM_W'(w); bus.h_in = DIM_W'(h);
        bus.colour_in = COLOUR_W'(c); bus.outline = outl[0];
        bus.start = do_start; bus.clear = do_clr;
        if (do_clr) build(0, 0, SW, SH, 0, 0);
        else build(xin, yin, w, h, c, outl);
        @(negedge clk);
        bus.start = 1'b0; bus.clear = 1'b0;
        if (exp_q.size() == 0) begin
            tests++;
            if ({bus.done, bus.plot, bus.busy} !== 3'b000) begin
                fails++; $display("FAIL zero_first done/plot/busy=%b want 000", {bus.done, bus.plot, bus.busy});
            end
            @(negedge clk);
            tests++;
            if ({bus.done, bus.plot, bus.busy} !== 3'b100) begin
                fails++; $display("FAIL zero_done done/plot/busy=%b want 100", {bus.done, bus.plot, bus.busy});
            end
            @(negedge clk);
            tests++;
            if ({bus.done, bus.plot, bus.busy} !== 3'b000) begin
                fails++; $display("FAIL zero_after done/plot/busy=%b want 000", {bus.done, bus.plot, bus.busy});
            end
            return;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            act_t = {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done};
            exp_t = {exp_q[i].x, exp_q[i].y, exp_q[i].c, exp_q[i].p, 1'b1, 1'b0};
            if (bus.plot === 1'b1) plots++;
            if (act_t !== exp_t) begin
                if (f_i < 0) begin f_i = i; f_act = act_t; f_exp = exp_t; end
                bad++;
            end
            if (noisy && i < exp_q.size() - 1) begin
                bus.start = 1'($urandom_range(0, 1)); bus.clear = 1'($urandom_range(0, 1));
                bus.x_in = X_W'($urandom); bus.y_in = Y_W'($urandom);
                bus.w_in = DIM_W'($urandom); bus.h_in = DIM_W'($urandom);
                bus.colour_in = COLOUR_W'($urandom); bus.outline = 1'($urandom);
            end else begin
                bus.start = 1'b0; bus.clear = 1'b0;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL pixels box(%0d,%0d,%0dx%0d): %0d bad, first at %0d {x,y,c,plot,busy,done} got %h want %h",
                     xin, yin, w, h, bad, f_i, f_act, f_exp);
        end
        @(negedge clk);
        tests++;
        if ({bus.done, bus.plot, bus.busy} !== 3'b100) begin
            fails++; $display("FAIL done_pulse done/plot/busy=%b want 100", {bus.done, bus.plot, bus.busy});
        end
        @(negedge clk);
        tests++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            fails++; $display("FAIL done_clear done/busy=%b want 00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done} !== 21'd0) begin
            fails++; $display("FAIL reset_outputs got %h want 0", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_box();
        int p;
        run_box(10, 20, 3, 2, 5, 0, 1'b1, 1'b0, 1'b0, p);
        tests++;
        if (p !== 6) begin fails++; $display("FAIL basic_plots got %0d want 6", p); end
    endtask

    task automatic test_outline();
        int p;
        run_box(30, 40, 4, 4, 3, 1, 1'b1, 1'b0, 1'b0, p);
        tests++;
        if (p !== 12) begin fails++; $display("FAIL outline_plots got %0d want 12", p); end
    endtask

    task automatic test_clip();
        int p;
        int want;
`ifdef PLOTTER_CLIP_EN
        want = 2;
`else
        want = 4;
`endif
        run_box(158, 5, 4, 1, 6, 0, 1'b1, 1'b0, 1'b0, p);
        tests++;
        if (p !== want) begin fails++; $display("FAIL clip_plots got %0d want %0d", p, want); end
    endtask

    task automatic test_zero_size_back_to_back();
        int p;
        run_box(7, 7, 0, 5, 2, 0, 1'b1, 1'b0, 1'b0, p);
        run_box(7, 7, 2, 2, 2, 0, 1'b1, 1'b0, 1'b0, p);
        tests++;
        if (p !== 4) begin fails++; $display("FAIL after_zero_plots got %0d want 4", p); end
    endtask

    task automatic test_random();
        int p;
        for (int n = 0; n < 24; n++) begin
            run_box($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 1),
                    1'b1, 1'b0, 1'b1, p);
        end
    endtask

    task automatic test_clear_start();
        int p;
        run_box(50, 50, 5, 5, 7, 0, 1'b1, 1'b1, 1'b1, p);
        tests++;
        if (p !== SW * SH) begin fails++; $display("FAIL clear_plots got %0d want %0d", p, SW * SH); end
    endtask

    task automatic test_reset_mid_draw();
        int p;
        int stray = 0;
        bus.x_in = 8'd5; bus.y_in = 7'd5; bus.w_in = 4'd15; bus.h_in = 4'd15;
        bus.colour_in = 3'd4; bus.outline = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done} !== 21'd0) begin
            fails++; $display("FAIL async_reset got %h want 0", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) stray++;
        end
        tests++;
        if (stray !== 0) begin fails++; $display("FAIL post_reset_idle active cycles %0d want 0", stray); end
        run_box(9, 9, 1, 1, 1, 0, 1'b1, 1'b0, 1'b0, p);
        tests++;
        if (p !== 1) begin fails++; $display("FAIL one_pixel_plots got %0d want 1", p); end
    endtask

    initial begin
        bus.start = 1'b0; bus.clear = 1'b0; bus.outline = 1'b0;
        bus.x_in = '0; bus.y_in = '0; bus.w_in = '0; bus.h_in = '0; bus.colour_in = '0;
        test_reset();
        test_basic_box();
        test_outline();
        test_clip();
        test_zero_size_back_to_back();
        test_random();
        test_clear_start();
        test_reset_mid_draw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
